// File: rtl/seq_mult6.sv
// Sequential shift-and-add unsigned multiplier with valid/ready handshakes on
// both the operand and product sides; one six_bit_adder forms each partial sum.

module six_bit_adder (
  input  logic [5:0] a,
  input  logic [5:0] b,
  input  logic       cin,
  output logic [5:0] sum,
  output logic       cout
);
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {6'd0, cin};
endmodule

module seq_mult6 #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               result_valid,
  input  logic               result_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] add_sum;
  logic             add_cout;
  logic [WIDTH-1:0] acc_nxt, mplier_nxt;
  logic             last_iter;

  six_bit_adder u_adder (
    .a    (acc),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Carry-out lands in the MSB of the shifted accumulator so it is never lost.
  always_comb begin
    acc_nxt    = {1'b0, acc[WIDTH-1:1]};
    mplier_nxt = {acc[0], mplier[WIDTH-1:1]};
    if (mplier[0]) begin
      acc_nxt    = {add_cout, add_sum[WIDTH-1:1]};
      mplier_nxt = {add_sum[0], mplier[WIDTH-1:1]};
    end
  end

  assign last_iter = (count == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = CALC;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_ready  = (state == IDLE);
    result_valid = (state == DONE);
    busy         = (state == CALC) || (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            count  <= '0;
          end
        end
        CALC: begin
          acc    <= acc_nxt;
          mplier <= mplier_nxt;
          count  <= count + CNT_W'(1);
          if (last_iter) product <= {acc_nxt, mplier_nxt};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult6.sv
// Bench for seq_mult6: directed vector table, backpressure and reset-abort
// sequences, and randomized operands checked against a plain a*b model.

module tb_seq_mult6;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [5:0]  a, b;
  logic        result_valid;
  logic        result_ready;
  logic [11:0] product;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  seq_mult6 #(.WIDTH(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .a            (a),
    .b            (b),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .product      (product),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation starting at a negedge; optionally stall the result.
  task automatic do_op(input logic [5:0] op_a, input logic [5:0] op_b,
                       input int bp, input logic [11:0] exp);
    int lat;
    logic [11:0] held;
    chk("start_ready_idle", 32'(start_ready), 32'd1);
    a = op_a; b = op_b; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    a = 6'($urandom); b = 6'($urandom);
    chk("busy_calc", 32'(busy), 32'd1);
    lat = 0;
    while (!result_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'd6);
    chk("product", 32'(product), 32'(exp));
    held = product;
    for (int i = 0; i < bp; i++) begin
      a = 6'($urandom); b = 6'($urandom); start_valid = 1'b1;
      @(negedge clk);
      chk("bp_valid_held", 32'(result_valid), 32'd1);
      chk("bp_product_held", 32'(product), 32'(held));
      chk("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start_valid  = 1'b0;
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    chk("valid_drop", 32'(result_valid), 32'd0);
    chk("back_to_idle", 32'(start_ready), 32'd1);
    chk("product_retained", 32'(product), 32'(exp));
  endtask

  initial begin
    int ok;
    logic [5:0] ra, rb;
    vecs[0] = '{6'd30,  6'd3,  12'h05A};
    vecs[1] = '{6'h3F,  6'h3F, 12'hF81};
    vecs[2] = '{6'd0,   6'h2D, 12'h000};
    vecs[3] = '{6'h2D,  6'd0,  12'h000};
    vecs[4] = '{6'd1,   6'd45, 12'd45};
    vecs[5] = '{6'd2,   6'd31, 12'd62};

    rst_n = 1'b0; start_valid = 1'b0; result_ready = 1'b0; a = '0; b = '0;
    #1;
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start_ready", 32'(start_ready), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table; vectors 4 and 5 run back to back.
    for (int i = 0; i < 6; i++) do_op(vecs[i].a, vecs[i].b, 0, vecs[i].exp);

    // Five stalled cycles in DONE with ignored start attempts.
    do_op(6'd13, 6'd11, 5, 12'd143);

    // Reset while count==3 aborts the operation.
    a = 6'd30; b = 6'd3; start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_state_idle", 32'(start_ready), 32'd1);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (result_valid) ok = 0;
    end
    chk("abort_no_valid", 32'(ok), 32'd1);
    do_op(6'd5, 6'd7, 0, 12'd35);

    // Randomized operands against the arithmetic model.
    for (int i = 0; i < 25; i++) begin
      ra = 6'($urandom);
      rb = 6'($urandom);
      do_op(ra, rb, int'($urandom_range(0, 3)), 12'(ra) * 12'(rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
